// File: rtl/pe_mem_port.sv
// pe_mem_port: PE-side memory port with load/store request queues,
// load-credit tracking and an in-order load-response queue.
//
// Ports:
//   clk, rst                  clock, sync active-high reset
//   pe_ld_addr/vld/rdy        PE load request
//   pe_st_addr/data/vld/rdy   PE store request
//   pe_ld_data/vld/rdy        load response to the PE
//   ld_addr/req/gnt           interconnect load request
//   ld_data/ld_data_vld       interconnect load return (no backpressure)
//   st_addr/data/req/gnt      interconnect store request
//   outstanding_cnt           load credits in use (debug)
module pe_mem_port #(
  parameter int LD_Q_DEPTH = 4,
  parameter int ST_Q_DEPTH = 4,
  parameter int RESP_DEPTH = 4,
  parameter int GLOBAL_MEM_ADDR_L = 16,
  parameter int GLOBAL_MEM_PER_BANK_ADDR_L = 12,
  parameter int DATA_L = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [GLOBAL_MEM_ADDR_L-1:0] pe_ld_addr,
  input  logic pe_ld_vld,
  output logic pe_ld_rdy,
  input  logic [GLOBAL_MEM_PER_BANK_ADDR_L-1:0] pe_st_addr,
  input  logic [DATA_L-1:0] pe_st_data,
  input  logic pe_st_vld,
  output logic pe_st_rdy,
  output logic [DATA_L-1:0] pe_ld_data,
  output logic pe_ld_data_vld,
  input  logic pe_ld_data_rdy,
  output logic [GLOBAL_MEM_ADDR_L-1:0] ld_addr,
  output logic ld_req,
  input  logic ld_gnt,
  input  logic [DATA_L-1:0] ld_data,
  input  logic ld_data_vld,
  output logic [GLOBAL_MEM_PER_BANK_ADDR_L-1:0] st_addr,
  output logic [DATA_L-1:0] st_data,
  output logic st_req,
  input  logic st_gnt,
  output logic [$clog2(RESP_DEPTH):0] outstanding_cnt
);

  localparam int LAW = $clog2(LD_Q_DEPTH);
  localparam int SAW = $clog2(ST_Q_DEPTH);
  localparam int RAW = $clog2(RESP_DEPTH);
  localparam int CW  = RAW + 1;
  localparam int AW  = GLOBAL_MEM_ADDR_L;
  localparam int BW  = GLOBAL_MEM_PER_BANK_ADDR_L;
  localparam int SEW = BW + DATA_L;

  // ---------------- load request FIFO ----------------
  logic [AW-1:0] ld_mem [LD_Q_DEPTH];
  logic [LAW:0]  ld_wp, ld_rp;
  logic          ld_empty, ld_full;
  logic          ld_push, ld_pop;

  assign ld_empty = (ld_wp == ld_rp);
  assign ld_full  = (ld_wp[LAW] != ld_rp[LAW]) &&
                    (ld_wp[LAW-1:0] == ld_rp[LAW-1:0]);

  assign ld_req  = !ld_empty &&
                   (outstanding_cnt < CW'(RESP_DEPTH));
  assign ld_pop  = ld_req && ld_gnt;
  // A full queue still accepts when its head leaves on this edge.
  assign pe_ld_rdy = !ld_full || ld_pop;
  assign ld_push   = pe_ld_vld && pe_ld_rdy;
  assign ld_addr   = ld_mem[ld_rp[LAW-1:0]];

  always_ff @(posedge clk) begin
    if (ld_push) ld_mem[ld_wp[LAW-1:0]] <= pe_ld_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_wp <= '0;
      ld_rp <= '0;
    end else begin
      if (ld_push) ld_wp <= ld_wp + (LAW+1)'(1);
      if (ld_pop)  ld_rp <= ld_rp + (LAW+1)'(1);
    end
  end

  // ---------------- store request FIFO ----------------
  logic [SEW-1:0] st_mem [ST_Q_DEPTH];
  logic [SAW:0]   st_wp, st_rp;
  logic           st_empty, st_full;
  logic           st_push, st_pop;

  assign st_empty = (st_wp == st_rp);
  assign st_full  = (st_wp[SAW] != st_rp[SAW]) &&
                    (st_wp[SAW-1:0] == st_rp[SAW-1:0]);

  assign st_req    = !st_empty;
  assign st_pop    = st_req && st_gnt;
  assign pe_st_rdy = !st_full || st_pop;
  assign st_push   = pe_st_vld && pe_st_rdy;
  assign {st_addr, st_data} = st_mem[st_rp[SAW-1:0]];

  always_ff @(posedge clk) begin
    if (st_push) st_mem[st_wp[SAW-1:0]] <= {pe_st_addr, pe_st_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_wp <= '0;
      st_rp <= '0;
    end else begin
      if (st_push) st_wp <= st_wp + (SAW+1)'(1);
      if (st_pop)  st_rp <= st_rp + (SAW+1)'(1);
    end
  end

  // ---------------- load response FIFO ----------------
  logic [DATA_L-1:0] rs_mem [RESP_DEPTH];
  logic [RAW:0]      rs_wp, rs_rp;
  logic              rs_empty, rs_full;
  logic              rs_push, rs_pop;
  logic              rst_q;

  // Returns landing right after reset belong to discarded requests.
  always_ff @(posedge clk) rst_q <= rst;

  assign rs_empty = (rs_wp == rs_rp);
  assign rs_full  = (rs_wp[RAW] != rs_rp[RAW]) &&
                    (rs_wp[RAW-1:0] == rs_rp[RAW-1:0]);

  assign rs_push        = ld_data_vld && !rst_q;
  assign pe_ld_data_vld = !rs_empty;
  assign rs_pop         = pe_ld_data_vld && pe_ld_data_rdy;
  assign pe_ld_data     = rs_mem[rs_rp[RAW-1:0]];

  always_ff @(posedge clk) begin
    if (rs_push) rs_mem[rs_wp[RAW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_wp <= '0;
      rs_rp <= '0;
    end else begin
      if (rs_push) rs_wp <= rs_wp + (RAW+1)'(1);
      if (rs_pop)  rs_rp <= rs_rp + (RAW+1)'(1);
    end
  end

  // ---------------- load credits ----------------
  // A credit is taken at grant and freed when the PE consumes the
  // response, so the response FIFO can never overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_cnt <= '0;
    end else if (ld_pop && !rs_pop) begin
      outstanding_cnt <= outstanding_cnt + CW'(1);
    end else if (!ld_pop && rs_pop) begin
      outstanding_cnt <= outstanding_cnt - CW'(1);
    end
  end

  // ---------------- protocol checks ----------------
  a_resp_ovf: assert property (
    @(posedge clk) disable iff (rst) !(rs_push && rs_full));
  a_ld_gnt: assert property (
    @(posedge clk) disable iff (rst) !(ld_gnt && !ld_req));
  a_st_gnt: assert property (
    @(posedge clk) disable iff (rst) !(st_gnt && !st_req));

endmodule

// File: tb/tb_pe_mem_port.sv
// tb_pe_mem_port: directed and randomized checks of pe_mem_port
// against a queue-based model of the PE/interconnect traffic.
module tb_pe_mem_port;

  logic clk = 0;
  logic rst = 1;
  logic [15:0] pe_ld_addr = '0;
  logic pe_ld_vld = 0;
  logic pe_ld_rdy;
  logic [11:0] pe_st_addr = '0;
  logic [31:0] pe_st_data = '0;
  logic pe_st_vld = 0;
  logic pe_st_rdy;
  logic [31:0] pe_ld_data;
  logic pe_ld_data_vld;
  logic pe_ld_data_rdy = 0;
  logic [15:0] ld_addr;
  logic ld_req;
  logic ld_gnt;
  logic [31:0] ld_data = '0;
  logic ld_data_vld = 0;
  logic [11:0] st_addr;
  logic [31:0] st_data;
  logic st_req;
  logic st_gnt;
  logic [2:0] outstanding_cnt;

  logic gnt_en = 0;
  logic st_gnt_en = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Interconnect grants only while a request is presented.
  always_comb ld_gnt = gnt_en & ld_req;
  always_comb st_gnt = st_gnt_en & st_req;

  always #5 clk = ~clk;

  pe_mem_port dut (
    .clk(clk), .rst(rst),
    .pe_ld_addr(pe_ld_addr), .pe_ld_vld(pe_ld_vld),
    .pe_ld_rdy(pe_ld_rdy),
    .pe_st_addr(pe_st_addr), .pe_st_data(pe_st_data),
    .pe_st_vld(pe_st_vld), .pe_st_rdy(pe_st_rdy),
    .pe_ld_data(pe_ld_data), .pe_ld_data_vld(pe_ld_data_vld),
    .pe_ld_data_rdy(pe_ld_data_rdy),
    .ld_addr(ld_addr), .ld_req(ld_req), .ld_gnt(ld_gnt),
    .ld_data(ld_data), .ld_data_vld(ld_data_vld),
    .st_addr(st_addr), .st_data(st_data),
    .st_req(st_req), .st_gnt(st_gnt),
    .outstanding_cnt(outstanding_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pe_ld_vld = 0; pe_st_vld = 0; ld_data_vld = 0;
    pe_ld_data_rdy = 0; gnt_en = 0; st_gnt_en = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++; if (ld_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_ld_req got %b exp 0", ld_req); end
    n_tests++; if (st_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_st_req got %b exp 0", st_req); end
    n_tests++; if (pe_ld_data_vld !== 1'b0) begin n_fail++;
      $display("FAIL rst_rsp_vld got %b exp 0", pe_ld_data_vld); end
    n_tests++; if (pe_ld_rdy !== 1'b1) begin n_fail++;
      $display("FAIL rst_ld_rdy got %b exp 1", pe_ld_rdy); end
    n_tests++; if (pe_st_rdy !== 1'b1) begin n_fail++;
      $display("FAIL rst_st_rdy got %b exp 1", pe_st_rdy); end
    n_tests++; if (outstanding_cnt !== 3'd0) begin n_fail++;
      $display("FAIL rst_cnt got %0d exp 0", outstanding_cnt); end
  endtask

  task automatic test_single_load();
    apply_reset();
    gnt_en = 1; pe_ld_data_rdy = 1;
    pe_ld_vld = 1; pe_ld_addr = 16'h10;
    #1;
    n_tests++; if (ld_req !== 1'b0) begin n_fail++;
      $display("FAIL sl_no_comb_req got %b exp 0", ld_req); end
    step(); pe_ld_vld = 0; #1;
    n_tests++; if (ld_req !== 1'b1 || ld_addr !== 16'h10) begin
      n_fail++;
      $display("FAIL sl_req got %b/%h exp 1/0010", ld_req, ld_addr);
    end
    step(); #1;
    n_tests++; if (ld_req !== 1'b0 || outstanding_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL sl_gnt got req %b cnt %0d exp 0/1",
               ld_req, outstanding_cnt);
    end
    ld_data = 32'hAB; ld_data_vld = 1;
    step(); ld_data_vld = 0; #1;
    n_tests++; if (pe_ld_data_vld !== 1'b1 || pe_ld_data !== 32'hAB) begin
      n_fail++;
      $display("FAIL sl_rsp got %b/%h exp 1/ab", pe_ld_data_vld, pe_ld_data);
    end
    n_tests++; if (outstanding_cnt !== 3'd1) begin n_fail++;
      $display("FAIL sl_cnt1 got %0d exp 1", outstanding_cnt); end
    step(); #1;
    n_tests++; if (pe_ld_data_vld !== 1'b0 || outstanding_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL sl_pop got %b/%0d exp 0/0",
               pe_ld_data_vld, outstanding_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_credit_stall();
    int grants = 0;
    bit rdy_ok = 1;
    bit rv;
    int due[$];
    apply_reset();
    gnt_en = 1; pe_ld_data_rdy = 0;
    for (int c = 0; c < 20; c++) begin
      pe_ld_vld = (c < 6);
      pe_ld_addr = 16'h100 + 16'(c);
      rv = (due.size() > 0) && (due[0] == c);
      ld_data_vld = rv;
      ld_data = 32'(c);
      #1;
      if (!pe_ld_rdy) rdy_ok = 0;
      if (ld_req && ld_gnt) begin
        grants++;
        due.push_back(c + 2);
      end
      if (rv) void'(due.pop_front());
      step();
    end
    idle_inputs(); #1;
    n_tests++; if (grants != 4) begin n_fail++;
      $display("FAIL cs_grants got %0d exp 4", grants); end
    n_tests++; if (ld_req !== 1'b0) begin n_fail++;
      $display("FAIL cs_req got %b exp 0", ld_req); end
    n_tests++; if (!rdy_ok) begin n_fail++;
      $display("FAIL cs_ld_rdy got dropped exp always 1"); end
    n_tests++; if (outstanding_cnt !== 3'd4) begin n_fail++;
      $display("FAIL cs_cnt got %0d exp 4", outstanding_cnt); end
    n_tests++; if (ld_addr !== 16'h104) begin n_fail++;
      $display("FAIL cs_head got %h exp 0104", ld_addr); end
  endtask

  task automatic test_grant_backpressure();
    bit stable = 1;
    logic [15:0] got[$];
    apply_reset();
    pe_ld_data_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      pe_ld_vld = 1; pe_ld_addr = 16'h20 + 16'(i);
      step();
    end
    pe_ld_vld = 0; #1;
    n_tests++; if (pe_ld_rdy !== 1'b0) begin n_fail++;
      $display("FAIL bp_full_rdy got %b exp 0", pe_ld_rdy); end
    for (int k = 0; k < 5; k++) begin
      if (ld_addr !== 16'h20 || ld_req !== 1'b1) stable = 0;
      step(); #1;
    end
    n_tests++; if (!stable) begin n_fail++;
      $display("FAIL bp_stable got %h exp 0020", ld_addr); end
    gnt_en = 1; #1;
    for (int i = 0; i < 4; i++) begin
      if (ld_req && ld_gnt) got.push_back(ld_addr);
      step(); #1;
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= got.size() || got[i] !== 16'h20 + 16'(i)) begin
        n_fail++;
        $display("FAIL bp_order%0d got %h exp %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, 16'h20 + 16'(i));
      end
    end
    idle_inputs();
  endtask

  task automatic test_store_path();
    bit stable = 1;
    bit prev_req = 0, prev_g = 0;
    logic [11:0] pa = '0;
    logic [31:0] pd = '0;
    logic [43:0] got[$];
    logic [43:0] exp_e;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      pe_st_vld = (c < 3);
      pe_st_addr = 12'(c + 1);
      pe_st_data = 32'((c + 1) * 32'h11);
      st_gnt_en = c[0];
      #1;
      if (prev_req && !prev_g && (st_addr !== pa || st_data !== pd))
        stable = 0;
      if (st_req && st_gnt) got.push_back({st_addr, st_data});
      prev_req = st_req; prev_g = st_req && st_gnt;
      pa = st_addr; pd = st_data;
      step();
    end
    idle_inputs(); #1;
    n_tests++; if (!stable) begin n_fail++;
      $display("FAIL st_stable got change while stalled exp hold"); end
    for (int i = 0; i < 3; i++) begin
      exp_e = {12'(i + 1), 32'((i + 1) * 32'h11)};
      n_tests++;
      if (i >= got.size() || got[i] !== exp_e) begin
        n_fail++;
        $display("FAIL st_order%0d got %h exp %h", i,
                 (i < got.size()) ? got[i] : 44'hx, exp_e);
      end
    end
    n_tests++; if (st_req !== 1'b0 || pe_st_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL st_empty got %b/%b exp 0/1", st_req, pe_st_rdy);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      pe_ld_vld = 1; pe_ld_addr = 16'h30 + 16'(i);
      step();
    end
    pe_ld_vld = 0;
    gnt_en = 1; step(); step(); gnt_en = 0;
    ld_data = 32'hD0; ld_data_vld = 1;
    step(); ld_data_vld = 0; #1;
    n_tests++; if (outstanding_cnt !== 3'd2 || pe_ld_data_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_pre got %0d/%b exp 2/1",
               outstanding_cnt, pe_ld_data_vld);
    end
    pe_ld_data_rdy = 1; gnt_en = 1;
    step(); pe_ld_data_rdy = 0; gnt_en = 0; #1;
    n_tests++; if (outstanding_cnt !== 3'd2) begin n_fail++;
      $display("FAIL sim_cnt got %0d exp 2", outstanding_cnt); end
    n_tests++; if (pe_ld_data_vld !== 1'b0 || ld_req !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_after got %b/%b exp 0/0", pe_ld_data_vld, ld_req);
    end

    apply_reset();
    for (int i = 0; i < 4; i++) begin
      pe_ld_vld = 1; pe_ld_addr = 16'h40 + 16'(i);
      step();
    end
    pe_ld_vld = 0; #1;
    n_tests++; if (pe_ld_rdy !== 1'b0) begin n_fail++;
      $display("FAIL full_rdy got %b exp 0", pe_ld_rdy); end
    pe_ld_vld = 1; pe_ld_addr = 16'h44; gnt_en = 1; #1;
    n_tests++; if (pe_ld_rdy !== 1'b1) begin n_fail++;
      $display("FAIL full_pp_rdy got %b exp 1", pe_ld_rdy); end
    step(); pe_ld_vld = 0; gnt_en = 0; #1;
    n_tests++; if (pe_ld_rdy !== 1'b0 || ld_addr !== 16'h41) begin
      n_fail++;
      $display("FAIL full_pp got %b/%h exp 0/0041", pe_ld_rdy, ld_addr);
    end
    gnt_en = 1; step(); step(); step(); gnt_en = 0; #1;
    n_tests++; if (ld_req !== 1'b0 || ld_addr !== 16'h44) begin
      n_fail++;
      $display("FAIL full_tail got %b/%h exp 0/0044", ld_req, ld_addr);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      pe_ld_vld = 1; pe_ld_addr = 16'h50 + 16'(i);
      step();
    end
    pe_ld_vld = 0;
    gnt_en = 1; step(); step(); gnt_en = 0; #1;
    n_tests++; if (outstanding_cnt !== 3'd2) begin n_fail++;
      $display("FAIL rm_pre got %0d exp 2", outstanding_cnt); end
    rst = 1; step(); rst = 0;
    ld_data = 32'hEE; ld_data_vld = 1; #1;
    n_tests++;
    if (ld_req !== 0 || st_req !== 0 || pe_ld_data_vld !== 0 ||
        pe_ld_rdy !== 1 || pe_st_rdy !== 1 || outstanding_cnt !== 0)
    begin
      n_fail++;
      $display("FAIL rm_state got %b%b%b%b%b cnt %0d exp 00011 cnt 0",
               ld_req, st_req, pe_ld_data_vld, pe_ld_rdy, pe_st_rdy,
               outstanding_cnt);
    end
    step(); ld_data_vld = 0; #1;
    n_tests++; if (pe_ld_data_vld !== 1'b0) begin n_fail++;
      $display("FAIL rm_drop got %b exp 0", pe_ld_data_vld); end
    pe_ld_vld = 1; pe_ld_addr = 16'h77; gnt_en = 1;
    step(); pe_ld_vld = 0; #1;
    n_tests++; if (ld_req !== 1'b1 || ld_addr !== 16'h77) begin
      n_fail++;
      $display("FAIL rm_next got %b/%h exp 1/0077", ld_req, ld_addr);
    end
    step(); #1;
    n_tests++; if (outstanding_cnt !== 3'd1) begin n_fail++;
      $display("FAIL rm_cnt got %0d exp 1", outstanding_cnt); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [15:0] pend[$];
    logic [31:0] vis[$];
    int          ret_due[$];
    logic [31:0] ret_dat[$];
    logic [43:0] stq[$];
    int cnt = 0;
    int last_due = 0;
    int due;
    bit rv, e_req, g, e_rdy, push, p, e_sreq, sg, e_srdy, spush;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      pe_ld_vld = ($urandom_range(0, 1) == 1);
      pe_ld_addr = 16'($urandom);
      gnt_en = ($urandom_range(0, 3) != 0);
      pe_ld_data_rdy = ($urandom_range(0, 2) != 0);
      rv = (ret_due.size() > 0) && (ret_due[0] == c);
      ld_data_vld = rv;
      ld_data = rv ? ret_dat[0] : $urandom;
      pe_st_vld = ($urandom_range(0, 1) == 1);
      pe_st_addr = 12'($urandom);
      pe_st_data = $urandom;
      st_gnt_en = ($urandom_range(0, 2) != 0);
      #1;
      e_req = (pend.size() > 0) && (cnt < 4);
      g = e_req && gnt_en;
      e_rdy = (pend.size() < 4) || g;
      push = pe_ld_vld && e_rdy;
      p = (vis.size() > 0) && pe_ld_data_rdy;
      e_sreq = stq.size() > 0;
      sg = e_sreq && st_gnt_en;
      e_srdy = (stq.size() < 4) || sg;
      spush = pe_st_vld && e_srdy;
      n_tests++; if (ld_req !== e_req) begin n_fail++;
        $display("FAIL rnd_ld_req c%0d got %b exp %b", c, ld_req, e_req); end
      if (e_req) begin
        n_tests++; if (ld_addr !== pend[0]) begin n_fail++;
          $display("FAIL rnd_ld_addr c%0d got %h exp %h",
                   c, ld_addr, pend[0]); end
      end
      n_tests++; if (pe_ld_rdy !== e_rdy) begin n_fail++;
        $display("FAIL rnd_ld_rdy c%0d got %b exp %b", c, pe_ld_rdy, e_rdy);
      end
      n_tests++; if (pe_ld_data_vld !== (vis.size() > 0)) begin n_fail++;
        $display("FAIL rnd_rsp_vld c%0d got %b exp %b",
                 c, pe_ld_data_vld, vis.size() > 0); end
      if (vis.size() > 0) begin
        n_tests++; if (pe_ld_data !== vis[0]) begin n_fail++;
          $display("FAIL rnd_rsp_data c%0d got %h exp %h",
                   c, pe_ld_data, vis[0]); end
      end
      n_tests++; if (outstanding_cnt !== 3'(cnt)) begin n_fail++;
        $display("FAIL rnd_cnt c%0d got %0d exp %0d",
                 c, outstanding_cnt, cnt); end
      n_tests++; if (st_req !== e_sreq || pe_st_rdy !== e_srdy) begin
        n_fail++;
        $display("FAIL rnd_st_hs c%0d got %b/%b exp %b/%b",
                 c, st_req, pe_st_rdy, e_sreq, e_srdy);
      end
      if (e_sreq) begin
        n_tests++; if ({st_addr, st_data} !== stq[0]) begin n_fail++;
          $display("FAIL rnd_st_head c%0d got %h exp %h",
                   c, {st_addr, st_data}, stq[0]); end
      end
      if (g) begin
        void'(pend.pop_front());
        due = c + int'($urandom_range(1, 3));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ret_due.push_back(due);
        ret_dat.push_back($urandom);
        cnt++;
      end
      if (push) pend.push_back(pe_ld_addr);
      if (p) begin
        void'(vis.pop_front());
        cnt--;
      end
      if (rv) begin
        vis.push_back(ret_dat[0]);
        void'(ret_dat.pop_front());
        void'(ret_due.pop_front());
      end
      if (sg) void'(stq.pop_front());
      if (spush) stq.push_back({pe_st_addr, pe_st_data});
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_credit_stall();
    test_grant_backpressure();
    test_store_path();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
